// File: rtl/char_ram_writer_pkg.sv
// Shared text-display definitions: geometry, control codes, states.
// Imported by the RAM writer and by the display read side.
package char_ram_writer_pkg;

  localparam int         COLS_DEF  = 80;
  localparam int         ROWS_DEF  = 60;
  localparam logic [7:0] BLANK_DEF = 8'h00;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/char_ram_writer_cursor.sv
// Row/column position counter with wrap against COLS/ROWS.
// Used both for the text cursor and for the clear sweep.
module char_cursor #(
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       home,
  input  logic       inc,
  input  logic       nl,
  input  logic       cr,
  input  logic       bs,
  output logic [6:0] row,
  output logic [6:0] col
);

  logic [6:0] row_d;
  logic [6:0] col_d;
  logic [6:0] row_nx;

  // next position; commands are mutually exclusive
  always_comb begin
    row_nx = (row == 7'(ROWS - 1)) ? 7'd0 : row + 7'd1;
    row_d  = row;
    col_d  = col;
    unique case (1'b1)
      home: begin
        row_d = 7'd0;
        col_d = 7'd0;
      end
      inc: begin
        if (col == 7'(COLS - 1)) begin
          col_d = 7'd0;
          row_d = row_nx;
        end else begin
          col_d = col + 7'd1;
        end
      end
      nl: begin
        col_d = 7'd0;
        row_d = row_nx;
      end
      cr: col_d = 7'd0;
      bs: if (col != 7'd0) col_d = col - 7'd1;
      default: ;
    endcase
  end

  // position register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= 7'd0;
      col <= 7'd0;
    end else begin
      row <= row_d;
      col <= col_d;
    end
  end

endmodule

// File: rtl/char_ram_writer.sv
// Character stream to text RAM writer: cursor handling,
// control codes and full-screen clear sweep.
module char_ram_writer
  import char_ram_writer_pkg::*;
#(
  parameter int         COLS  = COLS_DEF,
  parameter int         ROWS  = ROWS_DEF,
  parameter logic [7:0] BLANK = BLANK_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  output logic [13:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  output logic [6:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic        busy
);

  state_t      state_q;
  state_t      state_d;
  logic        p_valid;
  logic [7:0]  p_char;
  logic [6:0]  s_row;
  logic [6:0]  s_col;
  logic        s_end;
  logic        take;
  logic        done;
  logic        is_lf;
  logic        is_cr;
  logic        is_bs;
  logic        do_inc;
  logic        do_nl;
  logic        do_cr;
  logic        do_bs;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [7:0]  wr_din;

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_CLEAR);
  assign take     = in_valid && in_ready;
  assign s_end    = (s_row == 7'(ROWS - 1)) &&
                    (s_col == 7'(COLS - 1));
  assign done     = busy && s_end;
  assign is_lf    = (p_char == CH_LF);
  assign is_cr    = (p_char == CH_CR);
  assign is_bs    = (p_char == CH_BS);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  // FF switches to CLEAR on acceptance so in_ready drops at once
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR: if (s_end) state_d = ST_IDLE;
      ST_IDLE:  if (take && in_char == CH_FF) state_d = ST_CLEAR;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // accepted character stage; FF is consumed by the FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_valid <= 1'b0;
      p_char  <= 8'h00;
    end else begin
      p_valid <= take && (in_char != CH_FF);
      p_char  <= in_char;
    end
  end

  // decode the staged character against the current cursor
  always_comb begin
    do_inc  = 1'b0;
    do_nl   = 1'b0;
    do_cr   = 1'b0;
    do_bs   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = {cur_row, cur_col};
    wr_din  = p_char;
    if (p_valid) begin
      unique case (1'b1)
        is_lf: do_nl = 1'b1;
        is_cr: do_cr = 1'b1;
        is_bs: begin
          if (cur_col != 7'd0) begin
            do_bs   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = {cur_row, cur_col - 7'd1};
            wr_din  = BLANK;
          end
        end
        default: begin
          do_inc = 1'b1;
          wr_en  = 1'b1;
        end
      endcase
    end
  end

  char_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk   (clk),
    .reset (reset),
    .home  (done),
    .inc   (do_inc),
    .nl    (do_nl),
    .cr    (do_cr),
    .bs    (do_bs),
    .row   (cur_row),
    .col   (cur_col)
  );

  char_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_sweep (
    .clk   (clk),
    .reset (reset),
    .home  (done),
    .inc   (busy && !s_end),
    .nl    (1'b0),
    .cr    (1'b0),
    .bs    (1'b0),
    .row   (s_row),
    .col   (s_col)
  );

  // registered RAM write port; sweep has priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_we   <= 1'b0;
      ram_addr <= 14'd0;
      ram_din  <= BLANK;
    end else begin
      ram_we <= busy || wr_en;
      if (busy) begin
        ram_addr <= {s_row, s_col};
        ram_din  <= BLANK;
      end else if (wr_en) begin
        ram_addr <= wr_addr;
        ram_din  <= wr_din;
      end
    end
  end

endmodule

// File: tb/tb_char_ram_writer.sv
// Scoreboard bench for char_ram_writer: directed
// character streams, clear sweeps and reset abort.
module tb_char_ram_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        in_ready;
  logic [13:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [6:0]  cur_row;
  logic [6:0]  cur_col;
  logic        busy;

  logic [21:0] exq[$];
  logic [21:0] e;
  int errors = 0;
  int checks = 0;
  int nwr = 0;

  always #5 clk = ~clk;

  char_ram_writer dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_char  (in_char),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .busy     (busy)
  );

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [13:0] ad(int r, int c);
    return {7'(r), 7'(c)};
  endfunction

  task automatic expw(int r, int c, logic [7:0] d);
    exq.push_back({ad(r, c), d});
  endtask

  task automatic exp_sweep();
    for (int r = 0; r < 60; r++)
      for (int c = 0; c < 80; c++)
        expw(r, c, 8'h00);
  endtask

  task automatic send(logic [7:0] c);
    in_valid = 1'b1;
    in_char  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic settle();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chkcur(string nm, int r, int c);
    chk({nm, "_row"}, cur_row, r);
    chk({nm, "_col"}, cur_col, c);
  endtask

  task automatic wait_clear(string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 6000);
    chk({nm, "_cycles"}, n, 4800);
    chk({nm, "_ready"}, in_ready, 1);
    chkcur(nm, 0, 0);
  endtask

  // scoreboard monitor: every write must match the queue head
  always @(negedge clk) begin
    if (ram_we) begin
      checks++;
      nwr++;
      if (exq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h din %0h, required none",
                 ram_addr, ram_din);
      end else begin
        e = exq.pop_front();
        if ({ram_addr, ram_din} !== e) begin
          errors++;
          $display("FAIL write: got addr %0h din %0h required addr %0h din %0h",
                   ram_addr, ram_din, e[21:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    int n;
    int base;
    #12;
    chk("rst_we", ram_we, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    chkcur("rst", 0, 0);

    exp_sweep();
    @(negedge clk);
    reset = 1'b1;
    wait_clear("clear0");

    expw(0, 0, 8'h41);
    expw(0, 1, 8'h42);
    send(8'h41);
    send(8'h42);
    settle();
    chkcur("ab", 0, 2);

    for (int i = 2; i < 79; i++) begin
      expw(0, i, 8'h30 + 8'(i % 10));
      send(8'h30 + 8'(i % 10));
    end
    settle();
    chkcur("to79", 0, 79);
    expw(0, 79, 8'h5A);
    send(8'h5A);
    settle();
    chkcur("wrap_col", 1, 0);

    for (int i = 0; i < 58; i++) send(8'h0A);
    for (int i = 0; i < 79; i++) begin
      expw(59, i, 8'h61);
      send(8'h61);
    end
    settle();
    chkcur("to5979", 59, 79);
    expw(59, 79, 8'h5A);
    send(8'h5A);
    settle();
    chkcur("wrap_row", 0, 0);

    for (int i = 0; i < 3; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) begin
      expw(3, i, 8'h62);
      send(8'h62);
    end
    settle();
    chkcur("at35", 3, 5);
    send(8'h0A);
    settle();
    chkcur("lf", 4, 0);
    send(8'h0D);
    settle();
    chkcur("cr", 4, 0);
    send(8'h08);
    settle();
    chkcur("bs0", 4, 0);
    chk("bs0_nowrite", exq.size(), 0);
    expw(4, 0, 8'h63);
    expw(4, 1, 8'h64);
    send(8'h63);
    send(8'h64);
    settle();
    chkcur("at42", 4, 2);
    expw(4, 1, 8'h00);
    send(8'h08);
    settle();
    chkcur("bs", 4, 1);

    exp_sweep();
    expw(0, 0, 8'h51);
    in_valid = 1'b1;
    in_char  = 8'h0C;
    @(posedge clk);
    #1;
    in_char = 8'h51;
    chk("ff_ready0", in_ready, 0);
    n = 0;
    while (!in_ready && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ff_busy_cycles", n, 4800);
    @(posedge clk);
    #1;
    settle();
    chkcur("after_ff", 0, 1);

    exp_sweep();
    base = nwr;
    send(8'h0C);
    n = 0;
    while (nwr - base < 1000 && n < 6000) begin
      @(posedge clk);
      n++;
    end
    chk("sweep_progress", int'(n < 6000), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_we", ram_we, 0);
    chk("abort_busy", busy, 1);
    chk("abort_ready", in_ready, 0);
    chk("abort_addr", ram_addr, 0);
    exq.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_sweep();
    reset = 1'b1;
    wait_clear("clear_restart");

    settle();
    chk("queue_empty", exq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/char_ram_writer.md
CHAR_RAM_WRITER -- requirements
Module: char_ram_writer

Interface
Parameters:
REQ-001 The block SHALL have parameter COLS, default 80, meaning number of text columns (0..COLS-1).
REQ-002 The block SHALL have parameter ROWS, default 60, meaning number of text rows (0..ROWS-1).
REQ-003 The block SHALL have parameter BLANK, default 8'h00, meaning the byte written by clear and backspace.
Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock (pixel clock); all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous reset, active-low (0 = in reset).
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_char is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_char this cycle.
REQ-008 The block SHALL have port in_char, input, 8 bits: character code or control code.
REQ-009 The block SHALL have port ram_addr, output, 14 bits: write address {row[6:0], col[6:0]}.
REQ-010 The block SHALL have port ram_din, output, 8 bits: write data.
REQ-011 The block SHALL have port ram_we, output, 1 bit: write strobe, one cycle per write.
REQ-012 The block SHALL have port cur_row, output, 7 bits: current cursor row.
REQ-013 The block SHALL have port cur_col, output, 7 bits: current cursor column.
REQ-014 The block SHALL have port busy, output, 1 bit: a clear sweep is in progress.

Function
REQ-015 The block SHALL implement two states, CLEAR and IDLE, leaving reset in CLEAR.
REQ-016 A transfer SHALL occur on a rising clk edge where in_valid and in_ready are both 1; in_ready SHALL be 1 exactly when the state is IDLE.
REQ-017 After a transfer at edge N, ram_we SHALL be 1 for the cycle following edge N+1, with ram_addr = {cursor before update}; the cursor SHALL update at the same edge. Throughput SHALL be one character per cycle.
REQ-018 A printable code (any code not listed in REQ-019..022) SHALL write in_char at the cursor, then advance col; if col = COLS-1, col SHALL become 0 and row SHALL advance.
REQ-019 Code 8'h0A (LF) SHALL set col = 0 and advance row, with no write.
REQ-020 Code 8'h0D (CR) SHALL set col = 0, with no write.
REQ-021 Code 8'h08 (BS) with col > 0 SHALL decrement col and write BLANK at the new position; with col = 0 it SHALL be ignored (no write, no move).
REQ-022 Code 8'h0C (FF) SHALL enter CLEAR.
REQ-023 A row advance from ROWS-1 SHALL wrap to row 0; there SHALL be no scrolling.
REQ-024 In CLEAR, the block SHALL write BLANK to every cell, one per cycle, row-major from {0,0} to {ROWS-1,COLS-1} (ROWS*COLS writes; 4800 at defaults), then home the cursor to (0,0) and enter IDLE.
REQ-025 busy SHALL be 1 throughout CLEAR, and in_char SHALL NOT be accepted while busy.
REQ-026 Addresses with col >= COLS or row >= ROWS SHALL never be emitted.
REQ-027 Row and col counters SHALL be 7 bits, and comparisons SHALL use parameters, not power-of-two wrap.

Reset
REQ-028 While reset = 0: ram_we = 0, in_ready = 0, busy = 1, cur_row = 0, cur_col = 0, ram_addr = 0, ram_din = BLANK, state = CLEAR, sweep counter = 0.
REQ-029 On release, the block SHALL start the full clear sweep on the first edge, including after a reset asserted mid-sweep or mid-stream; no partial write SHALL complete after assertion.

Structure
REQ-030 COLS/ROWS defaults, the control codes (LF, CR, BS, FF) and state encodings SHALL live in a shared include, chardisplay_defs.vh, used by this block and the display.
REQ-031 The row/col cursor with wrap logic SHALL be one sub-module, char_cursor, instantiated twice: once for the cursor and once for the clear sweep.
REQ-032 ram_* outputs SHALL drive the write port of a dual-port character RAM; the display keeps the read port.

Verification
REQ-033 Release reset -> ram_we high for 4800 consecutive cycles, last address {7'd59,7'd79}, then busy = 0, in_ready = 1, cursor (0,0).
REQ-034 Send 'A','B' back-to-back after clear -> writes 8'h41 @ {0,0} and 8'h42 @ {0,1} on consecutive cycles; cursor (0,2).
REQ-035 Cursor at (0,79), send 'Z' -> write @ {0,79}, cursor (1,0); cursor at (59,79), send 'Z' -> cursor (0,0).
REQ-036 Cursor (3,5), send LF, CR, BS, BS at col 0 -> (4,0), (4,0), and no write for the BS at col 0; from (4,2), BS -> BLANK written @ {4,1}, cursor (4,1).
REQ-037 Send FF with in_valid held high -> in_ready = 0 for 4800 cycles, the next char is written @ {0,0}.
REQ-038 Assert reset at sweep cycle 1000 -> ram_we = 0 immediately; after release, the sweep restarts at {0,0}.
